apb_timer: RTL and testbench



---
 rtl/apb_timer.sv | 152 +++++++++++++++
 tb/tb_apb_timer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer.sv
// APB countdown timer: 16-bit prescaler, 32-bit counter,
// optional auto-reload and a level interrupt on expiry.
module apb_timer #(
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               apbs_psel,
  input  logic               apbs_penable,
  input  logic               apbs_pwrite,
  input  logic [W_PADDR-1:0] apbs_paddr,
  input  logic [W_DATA-1:0]  apbs_pwdata,
  output logic [W_DATA-1:0]  apbs_prdata,
  output logic               apbs_pready,
  output logic               apbs_pslverr,
  output logic               irq
);

  localparam logic [9:0] A_CTRL   = 10'd0;
  localparam logic [9:0] A_PRESC  = 10'd1;
  localparam logic [9:0] A_RELOAD = 10'd2;
  localparam logic [9:0] A_COUNT  = 10'd3;
  localparam logic [9:0] A_STATUS = 10'd4;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] count_q, count_d;
  logic        expired_q, expired_d;
  logic [15:0] pc_q, pc_d;

  logic [9:0]  word;
  logic        hit_ctrl, hit_presc, hit_reload;
  logic        hit_count, hit_status, mapped;
  logic        wr;
  logic        wr_ctrl, wr_presc, wr_reload;
  logic        wr_count, wr_status;
  logic        tick, tick_ok, at_zero;
  logic        unused;

  assign word = apbs_paddr[11:2];
  assign unused = ^{apbs_paddr[W_PADDR-1:12], apbs_paddr[1:0]};

  // Offset decode and write strobes for the access phase
  always_comb begin
    hit_ctrl   = (word == A_CTRL);
    hit_presc  = (word == A_PRESC);
    hit_reload = (word == A_RELOAD);
    hit_count  = (word == A_COUNT);
    hit_status = (word == A_STATUS);
    mapped     = hit_ctrl | hit_presc | hit_reload
               | hit_count | hit_status;
    wr         = apbs_psel & apbs_penable & apbs_pwrite;
    wr_ctrl    = wr & hit_ctrl;
    wr_presc   = wr & hit_presc;
    wr_reload  = wr & hit_reload;
    wr_count   = wr & hit_count;
    wr_status  = wr & hit_status;
  end

  // Prescaler tick; a CTRL write that disables drops the tick
  always_comb begin
    tick    = ctrl_q[0] & (pc_q == presc_q);
    tick_ok = tick & ~(wr_ctrl & ~apbs_pwdata[0]);
    at_zero = (count_q == 32'd0);
  end

  // Next-state logic; software writes override counter side effects
  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    reload_d  = reload_q;
    count_d   = count_q;
    expired_d = expired_q;
    pc_d      = 16'd0;

    if (ctrl_q[0] && !tick) begin
      pc_d = pc_q + 16'd1;
    end

    if (tick_ok) begin
      if (!at_zero) begin
        count_d = count_q - 32'd1;
      end else if (ctrl_q[1]) begin
        count_d = reload_q;
      end else begin
        ctrl_d[0] = 1'b0;
      end
    end

    if (wr_status && apbs_pwdata[0]) begin
      expired_d = 1'b0;
    end
    if (tick_ok && at_zero) begin
      expired_d = 1'b1;
    end

    if (wr_ctrl) begin
      ctrl_d = apbs_pwdata[2:0];
    end
    if (wr_presc) begin
      presc_d = apbs_pwdata[15:0];
    end
    if (wr_reload) begin
      reload_d = apbs_pwdata[31:0];
    end
    if (wr_count) begin
      count_d = apbs_pwdata[31:0];
      pc_d    = 16'd0;
    end
  end

  // Register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= 3'd0;
      presc_q   <= 16'd0;
      reload_q  <= 32'hffff_ffff;
      count_q   <= 32'd0;
      expired_q <= 1'b0;
      pc_q      <= 16'd0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      pc_q      <= pc_d;
    end
  end

  // Read mux, zero when not reading or on unmapped offsets
  always_comb begin
    apbs_prdata = '0;
    if (apbs_psel && !apbs_pwrite && !rst) begin
      case (1'b1)
        hit_ctrl:   apbs_prdata = {29'd0, ctrl_q};
        hit_presc:  apbs_prdata = {16'd0, presc_q};
        hit_reload: apbs_prdata = reload_q;
        hit_count:  apbs_prdata = count_q;
        hit_status: apbs_prdata = {31'd0, expired_q};
        default:    apbs_prdata = '0;
      endcase
    end
  end

  assign apbs_pready  = 1'b1;
  assign apbs_pslverr = apbs_psel & apbs_penable & ~mapped & ~rst;
  assign irq          = expired_q & ctrl_q[2];

endmodule

// File: tb/tb_apb_timer.sv
// Scoreboard bench for apb_timer: reset, auto-reload,
// one-shot, collisions, bus errors and prescaler masking.
module tb_apb_timer;

  localparam logic [15:0] A_CTRL   = 16'h000;
  localparam logic [15:0] A_PRESC  = 16'h004;
  localparam logic [15:0] A_RELOAD = 16'h008;
  localparam logic [15:0] A_COUNT  = 16'h00c;
  localparam logic [15:0] A_STATUS = 16'h010;

  logic        clk;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  int          n_cmp;
  int          n_bad;
  int unsigned cyc;
  logic [31:0] exp_q[$];

  apb_timer #(.W_PADDR(16), .W_DATA(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .apbs_psel    (psel),
    .apbs_penable (penable),
    .apbs_pwrite  (pwrite),
    .apbs_paddr   (paddr),
    .apbs_pwdata  (pwdata),
    .apbs_prdata  (prdata),
    .apbs_pready  (pready),
    .apbs_pslverr (pslverr),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               tag, obs, exp);
    end
  endtask

  task automatic sb_cmp(input string tag,
                        input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, obs, 32'hxxxx_xxxx);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic apb_wr(input logic [15:0] a,
                        input logic [31:0] d,
                        output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a,
                    input logic [31:0] d);
    logic e;
    apb_wr(a, d, e);
  endtask

  task automatic apb_rd(input logic [15:0] a,
                        output logic [31:0] d,
                        output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    d = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [15:0] a,
                        input logic [31:0] ed,
                        input logic ee);
    logic [31:0] d;
    logic        e;
    exp_q.push_back(ed);
    exp_q.push_back({31'd0, ee});
    apb_rd(a, d, e);
    sb_cmp(tag, d);
    sb_cmp({tag, "_err"}, {31'd0, e});
  endtask

  task automatic watch(input logic [15:0] a);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int unsigned e;
    int          n;
    logic        err;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;

    // reset state
    #2;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // raise irq, then reset mid-count
    wr(A_COUNT, 32'd1);
    wr(A_CTRL, 32'h5);
    n = 0;
    while (irq !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("irq_wait", {31'd0, irq}, 32'd1);
    wr(A_COUNT, 32'd5);
    wr(A_CTRL, 32'h5);
    chk("irq_pre_rst", {31'd0, irq}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("irq_async_rst", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_chk("r_ctrl", A_CTRL, 32'd0, 1'b0);
    rd_chk("r_presc", A_PRESC, 32'd0, 1'b0);
    rd_chk("r_reload", A_RELOAD, 32'hffff_ffff, 1'b0);
    rd_chk("r_count", A_COUNT, 32'd0, 1'b0);
    rd_chk("r_status", A_STATUS, 32'd0, 1'b0);

    // one-shot
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h5);
    repeat (2) @(posedge clk);
    #1;
    chk("os_irq_e2", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("os_irq_e3", {31'd0, irq}, 32'd1);
    rd_chk("os_ctrl", A_CTRL, 32'h4, 1'b0);
    rd_chk("os_count", A_COUNT, 32'd0, 1'b0);
    wr(A_STATUS, 32'd1);
    chk("os_w1c", {31'd0, irq}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("os_quiet", {31'd0, irq}, 32'd0);
    rd_chk("os_status", A_STATUS, 32'd0, 1'b0);

    // auto-reload period
    do_reset();
    wr(A_RELOAD, 32'd3);
    wr(A_PRESC, 32'd1);
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h7);
    e = cyc;
    watch(A_COUNT);
    for (int k = 0; k < 18; k++) begin
      if (k != 0) @(posedge clk);
      #1;
      exp_q.push_back(32'd3 - 32'((k % 8) / 2));
      exp_q.push_back({31'd0, k >= 8});
      sb_cmp($sformatf("ar_cnt%0d", k), prdata);
      sb_cmp($sformatf("ar_irq%0d", k), {31'd0, irq});
    end
    psel = 1'b0;

    // W1C on the same edge as an expiry
    wait_cyc(e + 21);
    wr(A_STATUS, 32'd1);
    chk("w1c_collide", {31'd0, irq}, 32'd1);
    wait_cyc(e + 25);
    wr(A_STATUS, 32'd1);
    chk("w1c_clear", {31'd0, irq}, 32'd0);
    rd_chk("w1c_status", A_STATUS, 32'd0, 1'b0);

    // COUNT write on a tick edge
    wait_cyc(e + 31);
    wr(A_COUNT, 32'h10);
    watch(A_COUNT);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(posedge clk);
      #1;
      exp_q.push_back(32'h10 - 32'(k / 2));
      sb_cmp($sformatf("cw_cnt%0d", k), prdata);
    end
    psel = 1'b0;

    // bus errors
    do_reset();
    apb_wr(16'h014, 32'hdead, err);
    chk("be_wr_err", {31'd0, err}, 32'd1);
    rd_chk("be_rd14", 16'h014, 32'd0, 1'b1);
    rd_chk("be_rd800", 16'h800, 32'd0, 1'b1);
    rd_chk("be_ctrl", A_CTRL, 32'd0, 1'b0);
    rd_chk("be_presc", A_PRESC, 32'd0, 1'b0);
    rd_chk("be_reload", A_RELOAD, 32'hffff_ffff, 1'b0);
    rd_chk("be_count", A_COUNT, 32'd0, 1'b0);
    rd_chk("be_status", A_STATUS, 32'd0, 1'b0);

    // prescaler masking and long tick
    wr(A_PRESC, 32'hffff_1234);
    rd_chk("ps_mask", A_PRESC, 32'h1234, 1'b0);
    wr(A_COUNT, 32'd1);
    wr(A_CTRL, 32'h5);
    watch(A_COUNT);
    repeat (32'h1234) @(posedge clk);
    #1;
    exp_q.push_back(32'd1);
    sb_cmp("ps_before", prdata);
    @(posedge clk); #1;
    exp_q.push_back(32'd0);
    sb_cmp("ps_tick", prdata);
    chk("ps_irq_lo", {31'd0, irq}, 32'd0);
    repeat (32'h1234) @(posedge clk);
    #1;
    chk("ps_irq_pre", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("ps_irq_exp", {31'd0, irq}, 32'd1);
    psel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
